// File: rtl/defines_pkg.sv
// Shared widths, opcode encodings and pipeline record types for the SPU execution core.
package defines_pkg;

    localparam int REG_W    = 128;
    localparam int ADDR_W   = 7;
    localparam int OPC_W    = 11;
    localparam int NUM_REGS = 128;
    localparam int RD_PORTS = 6;

    // Decoded instruction word field positions
    localparam int OPC_MSB = 56, OPC_LSB = 46;
    localparam int I18_MSB = 45, I18_LSB = 28;
    localparam int RA_MSB  = 27, RA_LSB  = 21;
    localparam int RB_MSB  = 20, RB_LSB  = 14;
    localparam int RC_MSB  = 13, RC_LSB  = 7;
    localparam int RT_MSB  = 6,  RT_LSB  = 0;

    localparam string EVENINSFILE = "even_ins.txt";
    localparam string ODDINSFILE  = "odd_ins.txt";

    // ISA opcodes left-aligned into 11 bits, short forms zero-padded on the right
    typedef enum logic [OPC_W-1:0] {
        OP_A       = 11'b00011000000,
        OP_AH      = 11'b00011001000,
        OP_AI      = 11'b00011100000,
        OP_SF      = 11'b00001000000,
        OP_AND     = 11'b00011000001,
        OP_OR      = 11'b00001000001,
        OP_XOR     = 11'b01001000001,
        OP_IL      = 11'b01000000100,
        OP_ILA     = 11'b01000010000,
        OP_NOP     = 11'b01000000001,
        OP_ROTQBY  = 11'b00111011100,
        OP_ROTQBYI = 11'b00111111100,
        OP_SHLQBYI = 11'b00111111111,
        OP_LNOP    = 11'b00000000001
    } Opcodes;

    typedef struct packed {
        Opcodes            opc;
        logic [ADDR_W-1:0] ra;
        logic [ADDR_W-1:0] rb;
        logic [ADDR_W-1:0] rc;
        logic [ADDR_W-1:0] rt;
        logic [9:0]        i10;
        logic [15:0]       i16;
        logic [17:0]       i18;
    } dec_e_t;

    typedef struct packed {
        Opcodes            opc;
        logic [ADDR_W-1:0] ra;
        logic [ADDR_W-1:0] rb;
        logic [ADDR_W-1:0] rc;
        logic [ADDR_W-1:0] rt;
        logic [4:0]        i7;
    } dec_o_t;

    typedef struct packed {
        logic              en;
        logic [ADDR_W-1:0] addr;
        logic [REG_W-1:0]  data;
    } wb_t;

    localparam dec_e_t DEC_E_NOP = '{opc: OP_NOP, ra: '0, rb: '0, rc: '0, rt: '0,
                                     i10: '0, i16: '0, i18: '0};
    localparam dec_o_t DEC_O_NOP = '{opc: OP_LNOP, ra: '0, rb: '0, rc: '0, rt: '0, i7: '0};

endpackage

// File: rtl/spu_regfile.sv
// 128 x 128-bit register file: six combinational read ports, two write ports, async clear.
module spu_regfile
    import defines_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst,
    input  logic [RD_PORTS-1:0][ADDR_W-1:0] rd_addr,
    output logic [RD_PORTS-1:0][REG_W-1:0]  rd_data,
    input  logic                           we_e,
    input  logic [ADDR_W-1:0]              wa_e,
    input  logic [REG_W-1:0]               wd_e,
    input  logic                           we_o,
    input  logic [ADDR_W-1:0]              wa_o,
    input  logic [REG_W-1:0]               wd_o
);

    logic [REG_W-1:0] mem [NUM_REGS];

    always_comb begin
        for (int i = 0; i < RD_PORTS; i++) begin
            rd_data[i] = mem[rd_addr[i]];
        end
    end

    // NOTE: every entry is cleared on reset, so this array maps to flops rather than a RAM macro.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (we_e) mem[wa_e] <= wd_e;
            // Odd write is issued last so it wins a same-address conflict.
            if (we_o) mem[wa_o] <= wd_o;
        end
    end

endmodule

// File: rtl/spu_pipes_top.sv
// Dual-issue SPU execute core: even fixed-point pipe + odd byte-permute pipe, D -> X -> WB.
// Define SPU_PIPES_FWD_EN to bypass X-stage results into D-stage operand reads.
module spu_pipes_top
    import defines_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  Opcodes            opcode_ep,
    input  Opcodes            opcode_op,
    input  logic [ADDR_W-1:0] ra_addr_ep,
    input  logic [ADDR_W-1:0] rb_addr_ep,
    input  logic [ADDR_W-1:0] rc_addr_ep,
    input  logic [ADDR_W-1:0] rt_addr_ep,
    input  logic [ADDR_W-1:0] ra_addr_op,
    input  logic [ADDR_W-1:0] rb_addr_op,
    input  logic [ADDR_W-1:0] rc_addr_op,
    input  logic [ADDR_W-1:0] rt_addr_op,
    input  logic [6:0]        in_I7e,
    input  logic [7:0]        in_I8e,
    input  logic [9:0]        in_I10e,
    input  logic [15:0]       in_I16e,
    input  logic [17:0]       in_I18e,
    input  logic [6:0]        in_I7o,
    input  logic [7:0]        in_I8o,
    input  logic [9:0]        in_I10o,
    input  logic [15:0]       in_I16o,
    input  logic [17:0]       in_I18o,
    output logic              wb_en_ep,
    output logic              wb_en_op,
    output logic [ADDR_W-1:0] wb_addr_ep,
    output logic [ADDR_W-1:0] wb_addr_op,
    output logic [REG_W-1:0]  wb_data_ep,
    output logic [REG_W-1:0]  wb_data_op
);

    dec_e_t d_e;
    dec_o_t d_o;
    wb_t    x_e, x_o, wb_e, wb_o, res_e, res_o;
    logic [RD_PORTS-1:0][REG_W-1:0] rd_data;
    logic [REG_W-1:0] ra_e, rb_e, rc_e, ra_o, rb_o, rc_o;

    function automatic wb_t exec_even(dec_e_t d, logic [REG_W-1:0] a, logic [REG_W-1:0] b);
        wb_t r;
        r = '{en: 1'b1, addr: d.rt, data: '0};
        case (d.opc)
            OP_A:   for (int i = 0; i < 4; i++) r.data[32*i +: 32] = a[32*i +: 32] + b[32*i +: 32];
            OP_AH:  for (int i = 0; i < 8; i++) r.data[16*i +: 16] = a[16*i +: 16] + b[16*i +: 16];
            OP_AI:  for (int i = 0; i < 4; i++)
                        r.data[32*i +: 32] = a[32*i +: 32] + {{22{d.i10[9]}}, d.i10};
            OP_SF:  for (int i = 0; i < 4; i++) r.data[32*i +: 32] = b[32*i +: 32] - a[32*i +: 32];
            OP_AND: r.data = a & b;
            OP_OR:  r.data = a | b;
            OP_XOR: r.data = a ^ b;
            OP_IL:  r.data = {4{{{16{d.i16[15]}}, d.i16}}};
            OP_ILA: r.data = {4{{14'b0, d.i18}}};
            default: r = '0;
        endcase
        return r;
    endfunction

    // Byte 0 is the MSB byte, so a left byte rotate is a left bit shift of the doubled word.
    function automatic wb_t exec_odd(dec_o_t d, logic [REG_W-1:0] a, logic [3:0] cnt);
        wb_t               r;
        logic [2*REG_W-1:0] dbl;
        r   = '{en: 1'b1, addr: d.rt, data: '0};
        dbl = '0;
        case (d.opc)
            OP_ROTQBY: begin
                dbl    = {a, a} << {cnt, 3'b000};
                r.data = dbl[2*REG_W-1:REG_W];
            end
            OP_ROTQBYI: begin
                dbl    = {a, a} << {d.i7[3:0], 3'b000};
                r.data = dbl[2*REG_W-1:REG_W];
            end
            OP_SHLQBYI: r.data = a << {d.i7, 3'b000};
            default:    r = '0;
        endcase
        return r;
    endfunction

`ifdef SPU_PIPES_FWD_EN
    function automatic logic [REG_W-1:0] bypass(logic [ADDR_W-1:0] addr, logic [REG_W-1:0] rf,
                                                wb_t xe, wb_t xo);
        if (xo.en && xo.addr == addr) return xo.data;
        if (xe.en && xe.addr == addr) return xe.data;
        return rf;
    endfunction
`endif

    spu_regfile u_regfile (
        .clk     (clk),
        .rst     (rst),
        .rd_addr ({d_o.rc, d_o.rb, d_o.ra, d_e.rc, d_e.rb, d_e.ra}),
        .rd_data (rd_data),
        .we_e    (x_e.en),
        .wa_e    (x_e.addr),
        .wd_e    (x_e.data),
        .we_o    (x_o.en),
        .wa_o    (x_o.addr),
        .wd_o    (x_o.data)
    );

    // NOTE: every signal written here gets its default first, so no path can infer a latch.
    always_comb begin
        ra_e = rd_data[0];
        rb_e = rd_data[1];
        rc_e = rd_data[2];
        ra_o = rd_data[3];
        rb_o = rd_data[4];
        rc_o = rd_data[5];
`ifdef SPU_PIPES_FWD_EN
        ra_e = bypass(d_e.ra, rd_data[0], x_e, x_o);
        rb_e = bypass(d_e.rb, rd_data[1], x_e, x_o);
        rc_e = bypass(d_e.rc, rd_data[2], x_e, x_o);
        ra_o = bypass(d_o.ra, rd_data[3], x_e, x_o);
        rb_o = bypass(d_o.rb, rd_data[4], x_e, x_o);
        rc_o = bypass(d_o.rc, rd_data[5], x_e, x_o);
`endif
        res_e = exec_even(d_e, ra_e, rb_e);
        res_o = exec_odd(d_o, ra_o, rb_o[3:0]);
    end

    // NOTE: pipeline registers use non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_e  <= DEC_E_NOP;
            d_o  <= DEC_O_NOP;
            x_e  <= '0;
            x_o  <= '0;
            wb_e <= '0;
            wb_o <= '0;
        end else begin
            d_e  <= '{opc: opcode_ep, ra: ra_addr_ep, rb: rb_addr_ep, rc: rc_addr_ep,
                      rt: rt_addr_ep, i10: in_I10e, i16: in_I16e, i18: in_I18e};
            d_o  <= '{opc: opcode_op, ra: ra_addr_op, rb: rb_addr_op, rc: rc_addr_op,
                      rt: rt_addr_op, i7: in_I7o[4:0]};
            x_e  <= res_e;
            x_o  <= res_o;
            wb_e <= x_e;
            wb_o <= x_o;
        end
    end

    assign wb_en_ep   = wb_e.en;
    assign wb_addr_ep = wb_e.addr;
    assign wb_data_ep = wb_e.data;
    assign wb_en_op   = wb_o.en;
    assign wb_addr_op = wb_o.addr;
    assign wb_data_op = wb_o.data;

    // Fields and operands no current opcode consumes.
    logic unused_ok;
    assign unused_ok = ^{rc_e, rc_o, rb_o, in_I7e, in_I8e, in_I7o[6:5], in_I8o, in_I10o,
                         in_I16o, in_I18o};

endmodule

// File: tb/tb_spu_pipes_top.sv
// Randomised self-checking bench for spu_pipes_top against an instruction-level reference model.
module tb_spu_pipes_top;
    import defines_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    Opcodes       opcode_ep, opcode_op;
    logic [6:0]   ra_addr_ep, rb_addr_ep, rc_addr_ep, rt_addr_ep;
    logic [6:0]   ra_addr_op, rb_addr_op, rc_addr_op, rt_addr_op;
    logic [6:0]   in_I7e, in_I7o;
    logic [7:0]   in_I8e, in_I8o;
    logic [9:0]   in_I10e, in_I10o;
    logic [15:0]  in_I16e, in_I16o;
    logic [17:0]  in_I18e, in_I18o;
    logic         wb_en_ep, wb_en_op;
    logic [6:0]   wb_addr_ep, wb_addr_op;
    logic [127:0] wb_data_ep, wb_data_op;

    spu_pipes_top dut (
        .clk(clk), .rst(rst),
        .opcode_ep(opcode_ep), .opcode_op(opcode_op),
        .ra_addr_ep(ra_addr_ep), .rb_addr_ep(rb_addr_ep), .rc_addr_ep(rc_addr_ep), .rt_addr_ep(rt_addr_ep),
        .ra_addr_op(ra_addr_op), .rb_addr_op(rb_addr_op), .rc_addr_op(rc_addr_op), .rt_addr_op(rt_addr_op),
        .in_I7e(in_I7e), .in_I8e(in_I8e), .in_I10e(in_I10e), .in_I16e(in_I16e), .in_I18e(in_I18e),
        .in_I7o(in_I7o), .in_I8o(in_I8o), .in_I10o(in_I10o), .in_I16o(in_I16o), .in_I18o(in_I18o),
        .wb_en_ep(wb_en_ep), .wb_en_op(wb_en_op),
        .wb_addr_ep(wb_addr_ep), .wb_addr_op(wb_addr_op),
        .wb_data_ep(wb_data_ep), .wb_data_op(wb_data_op)
    );

    typedef struct {
        Opcodes      opc;
        logic [6:0]  ra, rb, rt;
        logic [17:0] imm;
    } ins_t;

    typedef struct {
        bit           en;
        logic [6:0]   addr;
        logic [127:0] data;
    } res_t;

    localparam logic [127:0] Q   = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [127:0] ROT = 128'h030405060708090A0B0C0D0E0F000102;
`ifdef SPU_PIPES_FWD_EN
    localparam logic [31:0] DEP1_WORD = 32'd2;
`else
    localparam logic [31:0] DEP1_WORD = 32'd5;
`endif

    // arch: register file as committed at the current edge; seq: fully in-order program state
    logic [127:0] arch [128];
    logic [127:0] seq  [128];
    res_t pend_e[$], pend_o[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(string tag, logic [127:0] got, logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic ins_t mk(Opcodes op, int rt, int ra, int rb, logic [17:0] imm);
        ins_t t;
        t.opc = op; t.rt = 7'(rt); t.ra = 7'(ra); t.rb = 7'(rb); t.imm = imm;
        return t;
    endfunction

    function automatic logic [31:0] lane32(logic [127:0] v, int i);
        return v[127-32*i -: 32];
    endfunction
    function automatic logic [15:0] lane16(logic [127:0] v, int i);
        return v[127-16*i -: 16];
    endfunction
    function automatic logic [7:0] byte_at(logic [127:0] v, int i);
        return v[127-8*i -: 8];
    endfunction

    function automatic res_t model_even(ins_t in, logic [127:0] a, logic [127:0] b);
        res_t r;
        logic signed [9:0]  s10;
        logic signed [15:0] s16;
        logic [31:0] w;
        r.en = 1'b1; r.addr = in.rt; r.data = '0;
        s10 = in.imm[9:0];
        s16 = in.imm[15:0];
        case (in.opc)
            OP_A:   for (int i = 0; i < 4; i++) begin w = lane32(a, i) + lane32(b, i); r.data = {r.data[95:0], w}; end
            OP_AH:  for (int i = 0; i < 8; i++) r.data = {r.data[111:0], 16'(lane16(a, i) + lane16(b, i))};
            OP_AI:  for (int i = 0; i < 4; i++) begin w = lane32(a, i) + 32'(s10); r.data = {r.data[95:0], w}; end
            OP_SF:  for (int i = 0; i < 4; i++) begin w = lane32(b, i) - lane32(a, i); r.data = {r.data[95:0], w}; end
            OP_AND: r.data = a & b;
            OP_OR:  r.data = a | b;
            OP_XOR: r.data = a ^ b;
            OP_IL:  for (int i = 0; i < 4; i++) r.data = {r.data[95:0], 32'(s16)};
            OP_ILA: for (int i = 0; i < 4; i++) r.data = {r.data[95:0], 32'(in.imm)};
            default: begin r.en = 1'b0; r.addr = '0; end
        endcase
        return r;
    endfunction

    function automatic res_t model_odd(ins_t in, logic [127:0] a, logic [127:0] b);
        res_t r;
        int n;
        r.en = 1'b1; r.addr = in.rt; r.data = '0;
        case (in.opc)
            OP_ROTQBY, OP_ROTQBYI: begin
                n = (in.opc == OP_ROTQBY) ? int'(b[3:0]) : int'(in.imm[3:0]);
                for (int i = 0; i < 16; i++) r.data = {r.data[119:0], byte_at(a, (i + n) % 16)};
            end
            OP_SHLQBYI: begin
                n = int'(in.imm[4:0]);
                for (int i = 0; i < 16; i++) r.data = {r.data[119:0], (i + n < 16) ? byte_at(a, i + n) : 8'h00};
            end
            default: begin r.en = 1'b0; r.addr = '0; end
        endcase
        return r;
    endfunction

    task automatic drive(ins_t e, ins_t o);
        opcode_ep = e.opc; ra_addr_ep = e.ra; rb_addr_ep = e.rb; rc_addr_ep = e.rt; rt_addr_ep = e.rt;
        in_I7e = e.imm[6:0]; in_I8e = e.imm[7:0]; in_I10e = e.imm[9:0]; in_I16e = e.imm[15:0]; in_I18e = e.imm;
        opcode_op = o.opc; ra_addr_op = o.ra; rb_addr_op = o.rb; rc_addr_op = o.rt; rt_addr_op = o.rt;
        in_I7o = o.imm[6:0]; in_I8o = o.imm[7:0]; in_I10o = o.imm[9:0]; in_I16o = o.imm[15:0]; in_I18o = o.imm;
    endtask

    task automatic clear_model();
        pend_e.delete();
        pend_o.delete();
        for (int i = 0; i < 128; i++) begin arch[i] = '0; seq[i] = '0; end
    endtask

    // One issue slot: drive, capture at the edge, update the model, compare the writeback ports.
    task automatic step(ins_t e, ins_t o);
        res_t we, wo, re, ro;
        logic [127:0] ea, eb, oa, ob;
        we = '{en: 1'b0, addr: '0, data: '0};
        wo = '{en: 1'b0, addr: '0, data: '0};
        @(negedge clk);
        drive(e, o);
        @(posedge clk);
        if (pend_e.size() == 2) begin
            we = pend_e.pop_front();
            wo = pend_o.pop_front();
            if (we.en) arch[we.addr] = we.data;
            if (wo.en) arch[wo.addr] = wo.data;
        end
`ifdef SPU_PIPES_FWD_EN
        ea = seq[e.ra]; eb = seq[e.rb]; oa = seq[o.ra]; ob = seq[o.rb];
`else
        ea = arch[e.ra]; eb = arch[e.rb]; oa = arch[o.ra]; ob = arch[o.rb];
`endif
        re = model_even(e, ea, eb);
        ro = model_odd(o, oa, ob);
        pend_e.push_back(re);
        pend_o.push_back(ro);
        if (re.en) seq[re.addr] = re.data;
        if (ro.en) seq[ro.addr] = ro.data;
        #1;
        check("wb_en_ep", wb_en_ep, we.en);
        check("wb_en_op", wb_en_op, wo.en);
        if (we.en) begin
            check("wb_addr_ep", wb_addr_ep, we.addr);
            check("wb_data_ep", wb_data_ep, we.data);
        end
        if (wo.en) begin
            check("wb_addr_op", wb_addr_op, wo.addr);
            check("wb_data_op", wb_data_op, wo.data);
        end
    endtask

    ins_t NOPE, LNOP;

    task automatic run(ins_t e, ins_t o);
        step(e, o);
        step(NOPE, LNOP);
    endtask

    function automatic ins_t rand_even();
        ins_t t;
        case ($urandom_range(0, 10))
            0: t.opc = OP_A;    1: t.opc = OP_AH;   2: t.opc = OP_AI;  3: t.opc = OP_SF;
            4: t.opc = OP_AND;  5: t.opc = OP_OR;   6: t.opc = OP_XOR; 7: t.opc = OP_IL;
            8: t.opc = OP_ILA;  9: t.opc = OP_NOP;  default: t.opc = Opcodes'(11'h7FF);
        endcase
        t.ra = 7'($urandom_range(0, 15)); t.rb = 7'($urandom_range(0, 15));
        t.rt = 7'($urandom_range(0, 15)); t.imm = 18'($urandom);
        return t;
    endfunction

    function automatic ins_t rand_odd();
        ins_t t;
        case ($urandom_range(0, 4))
            0: t.opc = OP_ROTQBY;  1: t.opc = OP_ROTQBYI; 2: t.opc = OP_SHLQBYI;
            3: t.opc = OP_LNOP;    default: t.opc = Opcodes'(11'h555);
        endcase
        t.ra = 7'($urandom_range(0, 15)); t.rb = 7'($urandom_range(0, 15));
        t.rt = 7'($urandom_range(0, 15)); t.imm = 18'($urandom);
        return t;
    endfunction

    task automatic readback_all();
        for (int k = 0; k < 64; k++) step(mk(OP_OR, k, k, k, 0), mk(OP_ROTQBYI, k + 64, k + 64, 0, 0));
        step(NOPE, LNOP);
        step(NOPE, LNOP);
    endtask

    initial begin
        NOPE = mk(OP_NOP, 0, 0, 0, 0);
        LNOP = mk(OP_LNOP, 0, 0, 0, 0);
        rst = 1'b1;
        drive(NOPE, LNOP);
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        check("rst_wb_en_ep", wb_en_ep, 1'b0);
        check("rst_wb_en_op", wb_en_op, 1'b0);
        check("rst_wb_addr_ep", wb_addr_ep, 7'd0);
        check("rst_wb_addr_op", wb_addr_op, 7'd0);
        check("rst_wb_data_ep", wb_data_ep, 128'd0);
        check("rst_wb_data_op", wb_data_op, 128'd0);
        @(negedge clk);
        rst = 1'b0;

        // Immediate loads and dependent adds
        step(mk(OP_IL, 1, 0, 0, 18'd5), LNOP);
        step(mk(OP_IL, 2, 0, 0, 18'h3FFFD), LNOP);
        step(NOPE, LNOP);
        check("il_r1", wb_data_ep, {4{32'h00000005}});
        step(mk(OP_A, 3, 1, 2, 0), LNOP);
        check("il_r2", wb_data_ep, {4{32'hFFFFFFFD}});
        step(NOPE, LNOP);
        step(NOPE, LNOP);
        check("a_dep2", wb_data_ep, {4{32'd2}});
        step(mk(OP_IL, 12, 0, 0, 18'h3FFFD), LNOP);
        step(mk(OP_A, 13, 1, 12, 0), LNOP);
        step(NOPE, LNOP);
        step(NOPE, LNOP);
        check("a_dep1", wb_data_ep, {4{DEP1_WORD}});

        // ila / ai / ah lane boundaries
        step(mk(OP_ILA, 4, 0, 0, 18'h3FFFF), LNOP);
        step(NOPE, LNOP);
        step(mk(OP_AI, 5, 4, 0, 18'h3FFFF), LNOP);
        check("ila_r4", wb_data_ep, {4{32'h0003FFFF}});
        step(NOPE, LNOP);
        step(NOPE, LNOP);
        check("ai_r5", wb_data_ep, {4{32'h0003FFFE}});
        step(mk(OP_ILA, 15, 0, 0, 18'h10001), LNOP);
        step(mk(OP_IL, 14, 0, 0, 18'h3FFFF), LNOP);
        step(NOPE, LNOP);
        step(mk(OP_AH, 16, 14, 15, 0), LNOP);
        step(NOPE, LNOP);
        step(NOPE, LNOP);
        check("ah_nocarry", wb_data_ep, 128'd0);

        // Build r6 = bytes 00..0F, then exercise the odd pipe
        run(mk(OP_ILA, 20, 0, 0, 18'h00404), LNOP);
        run(mk(OP_ILA, 22, 0, 0, 18'h00C0D), LNOP);
        run(mk(OP_ILA, 21, 0, 0, 18'h00E0F), mk(OP_SHLQBYI, 23, 20, 0, 18'd2));
        run(mk(OP_OR, 20, 20, 23, 0), mk(OP_SHLQBYI, 24, 22, 0, 18'd2));
        run(mk(OP_OR, 21, 21, 24, 0), mk(OP_SHLQBYI, 25, 20, 0, 18'd12));
        run(NOPE, mk(OP_SHLQBYI, 26, 20, 0, 18'd8));
        run(mk(OP_A, 25, 25, 26, 0), mk(OP_SHLQBYI, 27, 20, 0, 18'd4));
        run(mk(OP_A, 25, 25, 27, 0), LNOP);
        run(mk(OP_SF, 6, 25, 21, 0), LNOP);
        step(NOPE, mk(OP_ROTQBYI, 7, 6, 0, 18'd3));
        check("r6_pattern", wb_data_ep, Q);
        step(NOPE, LNOP);
        step(NOPE, mk(OP_SHLQBYI, 8, 6, 0, 18'd16));
        check("rotqbyi3", wb_data_op, ROT);
        step(NOPE, LNOP);
        step(NOPE, LNOP);
        check("shlqbyi16_en", wb_en_op, 1'b1);
        check("shlqbyi16", wb_data_op, 128'd0);

        // Same-target conflict: odd result must survive
        step(mk(OP_IL, 9, 0, 0, 18'd1), mk(OP_ROTQBYI, 9, 6, 0, 18'd0));
        step(NOPE, LNOP);
        step(NOPE, LNOP);
        check("conflict_en_ep", wb_en_ep, 1'b1);
        check("conflict_en_op", wb_en_op, 1'b1);
        step(mk(OP_OR, 9, 9, 9, 0), LNOP);
        step(NOPE, LNOP);
        step(NOPE, LNOP);
        check("conflict_r9", wb_data_ep, Q);

        // Random dual-issue traffic, then full register readback
        for (int n = 0; n < 400; n++) step(rand_even(), rand_odd());
        readback_all();

        // Asynchronous reset with instructions in flight
        for (int n = 0; n < 6; n++) step(rand_even(), rand_odd());
        #1;
        rst = 1'b1;
        drive(NOPE, LNOP);
        #1;
        check("midrst_en_ep", wb_en_ep, 1'b0);
        check("midrst_en_op", wb_en_op, 1'b0);
        check("midrst_data_ep", wb_data_ep, 128'd0);
        clear_model();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 3; n++) step(NOPE, LNOP);
        readback_all();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spu_pipes_top.md
# spu_pipes_top

Dual-issue execution core of the SPU model. Each cycle it accepts one decoded even-pipe instruction (fixed-point arithmetic/logical) and one decoded odd-pipe instruction (quadword byte permute). It holds the shared 128 × 128-bit register file and writes results back through a 2-stage pipeline per side. It sits below the instruction fetch/decode front end, which supplies already-split opcode, register-address and immediate fields.

## Interface
Parameters: none; widths come from `defines_pkg`.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `opcode_ep`, `opcode_op`  in  `Opcodes` (11)  even/odd opcode.
- `ra_addr_ep`, `rb_addr_ep`, `rc_addr_ep`, `rt_addr_ep`  in  7 each  even-pipe source/target register.
- `ra_addr_op`, `rb_addr_op`, `rc_addr_op`, `rt_addr_op`  in  7 each  odd-pipe source/target register.
- `in_I7e`, `in_I8e`, `in_I10e`, `in_I16e`, `in_I18e`  in  7/8/10/16/18  even immediates; all are low slices of I18.
- `in_I7o`, `in_I8o`, `in_I10o`, `in_I16o`, `in_I18o`  in  7/8/10/16/18  odd immediates.
- `wb_en_ep`, `wb_en_op`  out  1  writeback valid.
- `wb_addr_ep`, `wb_addr_op`  out  7  writeback register.
- `wb_data_ep`, `wb_data_op`  out  128  writeback data.

## Operation
- Instruction word layout, as produced by decode: [56:46] opcode, [45:28] I18, [27:21] ra, [20:14] rb, [13:7] rc, [6:0] rt.
- Opcode values follow the SPU ISA, left-aligned into 11 bits and zero-padded on the right.
- Even pipe, word ops are 4 lanes × 32 bits:
  - `a`: ra+rb.
  - `ah`: 8 lanes × 16 bits, ra+rb.
  - `ai`: ra+sext(I10).
  - `sf`: rb−ra.
  - `and`, `or`, `xor`: bitwise on ra, rb.
  - `il`: sext(I16) into each word.
  - `ila`: zext(I18) into each word.
  - `nop`: no write.
- Odd pipe:
  - `rotqby`: rotate ra left by rb[3:0] bytes.
  - `rotqbyi`: rotate ra left by I7[3:0] bytes.
  - `shlqbyi`: shift ra left by I7[4:0] bytes, zero fill; a count ≥16 gives 0.
  - `lnop`: no write.
- Unknown opcode on either pipe: treated as a nop; no write.
- Arithmetic wraps modulo lane width; no flags.
- Byte 0 is bits [127:120] (big-endian quadword).
- Register file: 128 entries × 128 bits, 6 combinational read ports, 2 write ports. r0 is an ordinary register.
- Same-edge write conflict (both pipes target the same rt): the odd-pipe result wins.

## Timing
- Edge N: opcode, addresses and immediates are registered into the decode stage (D).
- Cycle after N: register file is read combinationally from D, and the execute unit computes.
- Edge N+1: result registered into the execute stage (X).
- Edge N+2: X moves to writeback. The `wb_*` outputs are registered, and the register-file write happens on this same edge. Latency is 2 edges from capture to architectural update.
- A dependent instruction captured at edge N+2 or later sees the new value. Captured at N+1 it sees stale data, unless forwarding is enabled.
- Reset, asynchronous, at any time:
  - All D/X/WB stages are cleared to nop.
  - `wb_en_*` = 0, `wb_addr_*` = 0, `wb_data_*` = 0.
  - All 128 registers = 0.
- Instructions in flight when reset asserts are discarded.

## Configuration
- `SPU_PIPES_FWD_EN` defined: D-stage operand reads bypass from both X-stage results, for any matching ra/rb/rc. Priority: odd X, then even X, then register file. Back-to-back dependent instructions see correct values.
- Not defined: no bypass. Operands come only from the register file.

## Structure
- `defines_pkg` holds:
  - the `Opcodes` enum (11-bit);
  - the instruction-field bit positions;
  - the `EVENINSFILE`/`ODDINSFILE` path strings;
  - widths: REG 128, ADDR 7.
- One sub-module, `spu_regfile` (6R/2W, async clear), is natural.
- The even and odd execute units stay as combinational functions inside the top.

## Test plan
- Reset, then `il` r1, 5 and `il` r2, −3 on even → `wb_data_ep` = 32'h00000005 ×4, then 32'hFFFFFFFD ×4; registers updated at edge N+2.
- `a` r3=r1+r2 issued 2 cycles after the `il` of r2 → every word = 2. With the same `a` issued 1 cycle later:
  - without `SPU_PIPES_FWD_EN` → stale r2 = 0, every word 5;
  - with `SPU_PIPES_FWD_EN` → every word 2.
- `ila` r4, 18'h3FFFF; `ai` r5=r4+(−1) → r4 words 0003FFFF, r5 words 0003FFFE; `ah` of 16'hFFFF+1 per half → 0 with no carry into the neighbouring half.
- Odd: r6 = 128'h000102…0F, `rotqbyi` r7,r6,I7=3 → 128'h030405…0F000102; `shlqbyi` I7=16 → 0.
- Both pipes target r9 on the same cycle → r9 holds the odd result; `wb_en_ep` and `wb_en_op` are both 1.
- Assert `rst` mid-stream with instructions in flight → `wb_en_*` drop immediately, no later writes, all registers read 0.
